// File: rtl/bus_if.sv
// Team request/grant bus: one request per grant, one rvalid response per grant.
interface bus_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rdata, rvalid, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rdata, rvalid, err
    );
endinterface

// File: rtl/bus_ram_slave.sv
// Word RAM responder on the team bus with programmable grant latency and window decode.
// Optional: define BUS_RAM_SLAVE_MISALIGN_ERR_EN to reject requests with addr[1:0] != 0.
module bus_ram_slave #(
    parameter logic [31:0] SLAVE_START = 32'h0,
    parameter logic [31:0] SLAVE_SIZE  = 32'h8000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    bus_if.slave bus
);

    localparam int unsigned DEPTH    = SLAVE_SIZE / 4;
    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WAIT_CYCLES);
    localparam logic [31:0]      WIN_MASK = ~(SLAVE_SIZE - 32'd1);

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       mem_q [DEPTH];

    logic              gnt;
    logic              in_win;
    logic              misalign;
    logic              hit;
    logic [IDX_W-1:0]  idx;

    assign gnt    = bus.req && (cnt_q == CNT_MAX);
    assign in_win = (bus.addr & WIN_MASK) == SLAVE_START;
    assign idx    = (DEPTH > 1) ? bus.addr[IDX_W+1:2] : '0;

`ifdef BUS_RAM_SLAVE_MISALIGN_ERR_EN
    assign misalign = bus.addr[1:0] != 2'b00;
`else
    assign misalign = 1'b0;
`endif

    // A granted request touches memory only when it decodes cleanly.
    assign hit = gnt && in_win && !misalign;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.req && !gnt) begin
                    state_d = WAIT;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (!bus.req || gnt) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        rvalid_d = gnt;
        err_d    = gnt && !(in_win && !misalign);
        rdata_d  = '0;
        if (hit && !bus.we) begin
            rdata_d = mem_q[idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // Memory keeps its contents across reset; writes are blocked while reset is held.
    always_ff @(posedge clk_i) begin
        if (hit && bus.we && rst_ni) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.be[i]) begin
                    mem_q[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.gnt    = gnt;
    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;
    assign bus.rdata  = rdata_q;

endmodule

// File: doc/bus_ram_slave.md
BUS_RAM_SLAVE -- requirements
Module: bus_ram_slave

Interface
REQ-001 SHALL have parameter SLAVE_START, default 32'h0, byte base address of the decoded window.
REQ-002 SHALL have parameter SLAVE_SIZE, default 32'h8000, window size in bytes (power of two, >= 4).
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, extra cycles between req assertion and gnt.
REQ-004 SHALL have clk_i  input  1  clock, rising edge.
REQ-005 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have bus  bus_if.slave  --  responder side of the team bus (fields below).
REQ-007 SHALL have bus.req  input  1  request valid.
REQ-008 SHALL have bus.gnt  output  1  request accepted this cycle.
REQ-009 SHALL have bus.addr  input  32  byte address.
REQ-010 SHALL have bus.we  input  1  1 = write, 0 = read.
REQ-011 SHALL have bus.be  input  4  byte enables, be[i] covers wdata[8i+7:8i].
REQ-012 SHALL have bus.wdata  input  32  write data.
REQ-013 SHALL have bus.rdata  output  32  read data, valid with rvalid.
REQ-014 SHALL have bus.rvalid  output  1  response valid, one per granted request.
REQ-015 SHALL have bus.err  output  1  error flag, qualified by rvalid.

Function
REQ-016 SHALL hold a word array of SLAVE_SIZE/4 entries, index addr[log2(SLAVE_SIZE)-1:2].
REQ-017 SHALL keep a wait counter cnt with states IDLE (cnt=0, no pending req) and WAIT (req held, cnt < WAIT_CYCLES).
REQ-018 SHALL drive gnt = req && (cnt == WAIT_CYCLES), combinationally; WAIT_CYCLES=0 gives same-cycle grant.
REQ-019 SHALL increment cnt each cycle req is high and gnt is low; SHALL clear cnt on gnt or when req drops (request abandoned, no response).
REQ-020 SHALL assert rvalid for exactly one cycle, the cycle after each gnt, for reads and writes.
REQ-021 SHALL, for an in-window read, return the addressed word on rdata with rvalid; err=0.
REQ-022 SHALL, for an in-window write, update only bytes with be[i]=1 at the gnt edge; rdata=0, err=0 in response.
REQ-023 SHALL treat (addr & ~(SLAVE_SIZE-1)) != SLAVE_START as out-of-window: grant normally, no memory access, respond rvalid=1, err=1, rdata=0.
REQ-024 SHALL support back-to-back grants with WAIT_CYCLES=0 (one per cycle, rvalid every cycle).
REQ-025 SHALL return new data for a read granted the cycle after a write to the same word.
REQ-026 SHALL drive rdata=0 and err=0 whenever rvalid=0.
REQ-027 SHALL ignore we, be, wdata and addr on cycles without gnt.

Reset
REQ-028 SHALL, while rst_ni=0, force rvalid=0, err=0, rdata=0, cnt=0; gnt follows REQ-018 with cnt=0.
REQ-029 SHALL abandon any WAIT-state request and any pending response when reset asserts mid-operation.
REQ-030 SHALL NOT reset memory contents.

Configuration
REQ-031 SHALL, with BUS_RAM_SLAVE_MISALIGN_ERR_EN defined, treat any granted request with addr[1:0] != 0 as an error: no memory access, rvalid=1, err=1, rdata=0.
REQ-032 SHALL, without BUS_RAM_SLAVE_MISALIGN_ERR_EN, ignore addr[1:0] and access the containing word.

Verification
REQ-033 SHALL cover: WAIT_CYCLES=0, write addr 0x10 wdata 0xDEADBEEF be 4'hF, then read 0x10 -> gnt same cycle each, rvalid next cycle, read rdata 0xDEADBEEF, err 0.
REQ-034 SHALL cover: write 0x20 0x11223344 be 4'hF, then write 0x20 0xAABBCCDD be 4'b0101, read 0x20 -> rdata 0x11BB33DD.
REQ-035 SHALL cover: WAIT_CYCLES=2, req held from cycle 0 -> gnt in cycle 2 only, rvalid in cycle 3; req dropped in cycle 1 -> no gnt, no rvalid, cnt back to 0.
REQ-036 SHALL cover: read addr 0x0001_0000 with default window -> gnt, rvalid=1, err=1, rdata=0; memory unchanged on write to same address.
REQ-037 SHALL cover: macro defined, read 0x12 -> err=1; macro undefined, read 0x12 -> word 0x10 returned, err=0.
REQ-038 SHALL cover: rst_ni low during WAIT (WAIT_CYCLES=3, cycle 1) -> rvalid stays 0, cnt=0 after release, prior memory contents intact.
